bpred_btb: RTL and testbench

- Parametrised branch target buffer with per-entry saturating counters; next generation of the ID/EX-stage `my_predictor`.
- Looks up the ID-stage PC and produces the next PC.
- Updates from the resolved EX-stage jump.
- Carries the ID prediction into EX so it can flag mispredicts itself.
- Adds full tagging, a stall/flush-aware prediction pipeline register, configurable counter width and performance counters.

---
 rtl/bpred_pkg.sv | 26 ++
 rtl/bpred_btb_if.sv | 38 +++
 rtl/bpred_sat_ctr_array.sv | 43 ++++
 rtl/bpred_btb.sv | 154 +++++++++++++++
 tb/tb_bpred_btb.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bpred_pkg.sv
// Shared types and helpers for the branch predictor: counter type, counter
// constants derived from a width, and the saturating update rule.
package bpred_pkg;

  localparam int CTR_W_MAX = 16;

  typedef logic [CTR_W_MAX-1:0] ctr_t;

  function automatic ctr_t ctr_weak_t(int w);
    return ctr_t'(1) << (w - 1);
  endfunction

  function automatic ctr_t ctr_weak_nt(int w);
    return (ctr_t'(1) << (w - 1)) - ctr_t'(1);
  endfunction

  function automatic ctr_t ctr_max(int w);
    return (ctr_t'(1) << w) - ctr_t'(1);
  endfunction

  function automatic ctr_t sat_update(ctr_t ctr, logic taken, ctr_t max);
    if (taken) return (ctr == max) ? ctr : ctr + ctr_t'(1);
    else       return (ctr == '0)  ? ctr : ctr - ctr_t'(1);
  endfunction

endpackage

// File: rtl/bpred_btb_if.sv
// Pipeline-side signal bundle of bpred_btb: ID lookup, EX resolve, prediction
// outputs and statistics. The master drives the pipeline side.
interface bpred_btb_if #(
  parameter int PC_W   = 32,
  parameter int STAT_W = 32
);
  logic              id_valid;
  logic              id_is_jump;
  logic [PC_W-1:0]   id_pc;
  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic [PC_W-1:0]   ex_pc;
  logic              ex_taken;
  logic [PC_W-1:0]   ex_target;
  logic              ex_redirect;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic [PC_W-1:0]   npc;
  logic              ex_mispredict;
  logic [STAT_W-1:0] stat_lookups;
  logic [STAT_W-1:0] stat_taken_pred;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output id_valid, id_is_jump, id_pc, stall, flush,
    output ex_valid, ex_pc, ex_taken, ex_target, ex_redirect,
    input  pred_taken, pred_target, npc, ex_mispredict,
    input  stat_lookups, stat_taken_pred, stat_mispredicts
  );

  modport slave (
    input  id_valid, id_is_jump, id_pc, stall, flush,
    input  ex_valid, ex_pc, ex_taken, ex_target, ex_redirect,
    output pred_taken, pred_target, npc, ex_mispredict,
    output stat_lookups, stat_taken_pred, stat_mispredicts
  );
endinterface

// File: rtl/bpred_sat_ctr_array.sv
// Direction-counter storage with allocate (weak init) or saturating update on write.
// Reads are asynchronous and return the pre-write contents in the write cycle.
module bpred_sat_ctr_array
  import bpred_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(ENTRIES)-1:0] i_rd_idx,
  output logic [CTR_W-1:0]           o_rd_ctr,
  input  logic                       i_wr_en,
  input  logic [$clog2(ENTRIES)-1:0] i_wr_idx,
  input  logic                       i_wr_alloc,
  input  logic                       i_wr_taken
);
  localparam ctr_t WEAK_T  = ctr_weak_t(CTR_W);
  localparam ctr_t WEAK_NT = ctr_weak_nt(CTR_W);
  localparam ctr_t CTR_MAX = ctr_max(CTR_W);

  logic [CTR_W-1:0] r_ctr [ENTRIES];
  logic [CTR_W-1:0] w_cur;
  logic [CTR_W-1:0] w_next;

  assign o_rd_ctr = r_ctr[i_rd_idx];
  assign w_cur    = r_ctr[i_wr_idx];

  always_comb begin
    w_next = w_cur;
    if (i_wr_alloc) w_next = i_wr_taken ? CTR_W'(WEAK_T) : CTR_W'(WEAK_NT);
    else            w_next = CTR_W'(sat_update(ctr_t'(w_cur), i_wr_taken, CTR_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= '0;
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= w_next;
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// Tagged BTB with saturating direction counters, ID->EX prediction register,
// mispredict flag and saturating statistics. Define BPRED_GSHARE_EN for gshare counter indexing.
module bpred_btb
  import bpred_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 32,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic       clk,
  input  logic       rst,
  bpred_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
  } btb_entry_t;

  btb_entry_t        r_btb [ENTRIES];
  logic              r_p_valid;
  logic              r_p_taken;
  logic [PC_W-1:0]   r_p_target;
  logic [STAT_W-1:0] r_stat_lookups;
  logic [STAT_W-1:0] r_stat_taken_pred;
  logic [STAT_W-1:0] r_stat_mispredicts;

  logic [IDX_W-1:0]  w_id_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic [IDX_W-1:0]  w_rd_cidx;
  logic [IDX_W-1:0]  w_wr_cidx;
  logic [TAG_W-1:0]  w_id_tag;
  logic [TAG_W-1:0]  w_ex_tag;
  logic              w_id_jump;
  logic              w_id_hit;
  logic              w_ex_hit;
  logic              w_pred_taken;
  logic [PC_W-1:0]   w_pred_target;
  logic              w_mispredict;
  logic [CTR_W-1:0]  w_rd_ctr;
  logic              w_unused;

  assign w_id_idx  = bus.id_pc[IDX_W+1:2];
  assign w_id_tag  = bus.id_pc[PC_W-1:IDX_W+2];
  assign w_ex_idx  = bus.ex_pc[IDX_W+1:2];
  assign w_ex_tag  = bus.ex_pc[PC_W-1:IDX_W+2];
  assign w_id_jump = bus.id_valid && bus.id_is_jump;

  assign w_id_hit      = w_id_jump && r_btb[w_id_idx].valid && (r_btb[w_id_idx].tag == w_id_tag);
  assign w_ex_hit      = r_btb[w_ex_idx].valid && (r_btb[w_ex_idx].tag == w_ex_tag);
  assign w_pred_taken  = w_id_hit && w_rd_ctr[CTR_W-1];
  assign w_pred_target = w_pred_taken ? r_btb[w_id_idx].target : '0;

  assign w_mispredict = bus.ex_valid && r_p_valid &&
                        ((r_p_taken != bus.ex_taken) ||
                         (bus.ex_taken && (r_p_target != bus.ex_target)));

  assign bus.pred_taken       = w_pred_taken;
  assign bus.pred_target      = w_pred_target;
  assign bus.npc              = bus.ex_redirect ? bus.ex_target :
                                (w_pred_taken ? w_pred_target : bus.id_pc + PC_W'(4));
  assign bus.ex_mispredict    = w_mispredict;
  assign bus.stat_lookups     = r_stat_lookups;
  assign bus.stat_taken_pred  = r_stat_taken_pred;
  assign bus.stat_mispredicts = r_stat_mispredicts;

`ifdef BPRED_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;
  logic [IDX_W-1:0] r_p_ghr;

  assign w_rd_cidx = w_id_idx ^ r_ghr;
  // Train the counter that made the prediction; fall back to live history without one.
  assign w_wr_cidx = w_ex_idx ^ (r_p_valid ? r_p_ghr : r_ghr);
  assign w_unused  = ^{bus.ex_pc[1:0], w_rd_ctr, r_p_ghr[IDX_W-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghr   <= '0;
      r_p_ghr <= '0;
    end else begin
      if (!bus.flush && !bus.stall) r_p_ghr <= r_ghr;
      if (w_mispredict)      r_ghr <= {r_p_ghr[IDX_W-2:0], bus.ex_taken};
      else if (bus.ex_valid) r_ghr <= {r_ghr[IDX_W-2:0], bus.ex_taken};
    end
  end
`else
  assign w_rd_cidx = w_id_idx;
  assign w_wr_cidx = w_ex_idx;
  assign w_unused  = ^{bus.ex_pc[1:0], w_rd_ctr};
`endif

  bpred_sat_ctr_array #(
    .ENTRIES(ENTRIES),
    .CTR_W  (CTR_W)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .i_rd_idx  (w_rd_cidx),
    .o_rd_ctr  (w_rd_ctr),
    .i_wr_en   (bus.ex_valid),
    .i_wr_idx  (w_wr_cidx),
    .i_wr_alloc(!w_ex_hit),
    .i_wr_taken(bus.ex_taken)
  );

  // A miss replaces the whole entry; a hit refreshes the target only when taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_btb[i] <= '0;
    end else if (bus.ex_valid) begin
      if (!w_ex_hit) begin
        r_btb[w_ex_idx].valid  <= 1'b1;
        r_btb[w_ex_idx].tag    <= w_ex_tag;
        r_btb[w_ex_idx].target <= bus.ex_target;
      end else if (bus.ex_taken) begin
        r_btb[w_ex_idx].target <= bus.ex_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_valid  <= 1'b0;
      r_p_taken  <= 1'b0;
      r_p_target <= '0;
    end else if (bus.flush) begin
      r_p_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_p_valid  <= w_id_jump;
      r_p_taken  <= w_pred_taken;
      r_p_target <= w_pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_lookups     <= '0;
      r_stat_taken_pred  <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_id_jump && !bus.stall && (r_stat_lookups != '1))
        r_stat_lookups <= r_stat_lookups + STAT_W'(1);
      if (w_pred_taken && !bus.stall && (r_stat_taken_pred != '1))
        r_stat_taken_pred <= r_stat_taken_pred + STAT_W'(1);
      if (w_mispredict && (r_stat_mispredicts != '1))
        r_stat_mispredicts <= r_stat_mispredicts + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_bpred_btb.sv
// Bench for bpred_btb: directed scenarios then random traffic, checked against a
// table-level reference model; a second instance with 2-bit statistics checks saturation.
module tb_bpred_btb;
  localparam int ENTRIES = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpred_btb_if #(.PC_W(32), .STAT_W(32)) bus ();
  bpred_btb_if #(.PC_W(32), .STAT_W(2))  bus_s ();

  bpred_btb #(.ENTRIES(ENTRIES), .PC_W(32), .CTR_W(2), .STAT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  bpred_btb #(.ENTRIES(ENTRIES), .PC_W(32), .CTR_W(2), .STAT_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s));

  assign bus_s.id_valid    = bus.id_valid;
  assign bus_s.id_is_jump  = bus.id_is_jump;
  assign bus_s.id_pc       = bus.id_pc;
  assign bus_s.stall       = bus.stall;
  assign bus_s.flush       = bus.flush;
  assign bus_s.ex_valid    = bus.ex_valid;
  assign bus_s.ex_pc       = bus.ex_pc;
  assign bus_s.ex_taken    = bus.ex_taken;
  assign bus_s.ex_target   = bus.ex_target;
  assign bus_s.ex_redirect = bus.ex_redirect;

  // reference model: per-entry state as plain numbers
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int unsigned m_ctr   [ENTRIES];
  bit          mp_valid, mp_taken;
  int unsigned mp_tgt;
  longint      st_look, st_tp, st_mis;

  bit          e_jump, e_pt, e_mis;
  int unsigned e_ptgt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] pc_pool [8] = '{32'h100, 32'h200, 32'h40, 32'h44,
                               32'h1100, 32'h80, 32'hFFFF_FFFC, 32'h300};
  logic [31:0] tg_pool [4] = '{32'h200, 32'h300, 32'h400, 32'h1000};

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(longint v, longint m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    mp_valid = 0; mp_taken = 0; mp_tgt = 0;
    st_look = 0; st_tp = 0; st_mis = 0;
  endtask

  task automatic drive(bit idv, bit jmp, logic [31:0] pc, bit exv, logic [31:0] expc,
                       bit ext, logic [31:0] extgt, bit redir, bit stl, bit fl);
    bus.id_valid = idv; bus.id_is_jump = jmp; bus.id_pc = pc;
    bus.ex_valid = exv; bus.ex_pc = expc; bus.ex_taken = ext;
    bus.ex_target = extgt; bus.ex_redirect = redir; bus.stall = stl; bus.flush = fl;
  endtask

  task automatic lookup(logic [31:0] pc);
    drive(1, 1, pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic update(logic [31:0] pc, bit tk, logic [31:0] tgt);
    drive(0, 0, 0, 1, pc, tk, tgt, 0, 0, 0);
  endtask

  // Compute what the outputs must be for the current inputs and compare.
  task automatic sample_check();
    int unsigned i, t, npc;
    bit hit;
    #1;
    i      = (bus.id_pc / 4) % ENTRIES;
    t      = bus.id_pc / (ENTRIES * 4);
    e_jump = bus.id_valid && bus.id_is_jump;
    hit    = e_jump && m_valid[i] && (m_tag[i] == t);
    e_pt   = hit && (m_ctr[i] >= 2);
    e_ptgt = e_pt ? m_tgt[i] : 0;
    npc    = bus.id_pc + 32'd4;
    if (e_pt) npc = e_ptgt;
    if (bus.ex_redirect) npc = bus.ex_target;
    e_mis  = bus.ex_valid && mp_valid &&
             ((mp_taken != bus.ex_taken) || (bus.ex_taken && (mp_tgt != bus.ex_target)));
    check("pred_taken", bus.pred_taken, e_pt);
    check("pred_target", bus.pred_target, e_ptgt);
    check("npc", bus.npc, npc);
    check("ex_mispredict", bus.ex_mispredict, e_mis);
    check("stat_lookups", bus.stat_lookups, st_look);
    check("stat_taken_pred", bus.stat_taken_pred, st_tp);
    check("stat_mispredicts", bus.stat_mispredicts, st_mis);
    check("s2_lookups", bus_s.stat_lookups, sat(st_look, 3));
    check("s2_taken_pred", bus_s.stat_taken_pred, sat(st_tp, 3));
    check("s2_mispredicts", bus_s.stat_mispredicts, sat(st_mis, 3));
  endtask

  // Clock edge: advance the model with the inputs seen at the edge.
  task automatic advance();
    bit c_rst, c_stall, c_flush, c_exv, c_ext;
    logic [31:0] c_expc, c_extgt;
    int unsigned j, et;
    c_rst = rst; c_stall = bus.stall; c_flush = bus.flush;
    c_exv = bus.ex_valid; c_ext = bus.ex_taken; c_expc = bus.ex_pc; c_extgt = bus.ex_target;
    @(posedge clk);
    if (!c_rst) begin
      if (e_mis) st_mis++;
      if (e_jump && !c_stall) st_look++;
      if (e_pt && !c_stall) st_tp++;
      if (c_flush) mp_valid = 0;
      else if (!c_stall) begin
        mp_valid = e_jump; mp_taken = e_pt; mp_tgt = e_ptgt;
      end
      if (c_exv) begin
        j  = (c_expc / 4) % ENTRIES;
        et = c_expc / (ENTRIES * 4);
        if (m_valid[j] && m_tag[j] == et) begin
          if (c_ext) begin
            if (m_ctr[j] < 3) m_ctr[j]++;
            m_tgt[j] = c_extgt;
          end else if (m_ctr[j] > 0) m_ctr[j]--;
        end else begin
          m_valid[j] = 1; m_tag[j] = et; m_tgt[j] = c_extgt;
          m_ctr[j] = c_ext ? 2 : 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    sample_check();
    advance();
  endtask

  initial begin
    bit tk;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    sample_check();
    advance();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

    // cold lookup
    lookup(32'h100); sample_check();
    check("cold_taken", bus.pred_taken, 0);
    check("cold_npc", bus.npc, 32'h104);
    advance();

    // allocate then weaken
    update(32'h100, 1, 32'h200); cycle();
    lookup(32'h100); sample_check();
    check("alloc_taken", bus.pred_taken, 1);
    check("alloc_npc", bus.npc, 32'h200);
    advance();
    update(32'h100, 0, 0); cycle();
    lookup(32'h100); sample_check();
    check("weak_nt_taken", bus.pred_taken, 0);
    check("weak_nt_npc", bus.npc, 32'h104);
    advance();

    // saturation at 0x40
    for (int k = 0; k < 5; k++) begin update(32'h40, 1, 32'h80); cycle(); end
    lookup(32'h40); sample_check(); check("sat_hi_taken", bus.pred_taken, 1); advance();
    update(32'h40, 0, 0); cycle();
    lookup(32'h40); sample_check(); check("sat_one_nt", bus.pred_taken, 1); advance();
    update(32'h40, 0, 0); cycle();
    update(32'h40, 0, 0); cycle();
    lookup(32'h40); sample_check();
    check("sat_three_nt", bus.pred_taken, 0);
    check("sat_npc", bus.npc, 32'h44);
    advance();

    // tag alias
    update(32'h100, 1, 32'h200); cycle();
    lookup(32'h200); sample_check(); check("alias_miss", bus.pred_taken, 0); advance();
    update(32'h200, 1, 32'h300); cycle();
    lookup(32'h100); sample_check(); check("alias_evicted", bus.pred_taken, 0); advance();
    lookup(32'h200); sample_check(); check("alias_new_npc", bus.npc, 32'h300); advance();

    // mispredict on target, redirect precedence, flush+stall
    update(32'h100, 1, 32'h200); cycle();
    lookup(32'h100); sample_check(); check("mp_pred_tgt", bus.pred_target, 32'h200); advance();
    update(32'h100, 1, 32'h300); sample_check();
    check("mp_flag", bus.ex_mispredict, 1);
    advance();
    drive(1, 1, 32'h100, 0, 0, 0, 32'h400, 1, 0, 0); sample_check();
    check("redirect_npc", bus.npc, 32'h400);
    advance();
    drive(1, 1, 32'h100, 0, 0, 0, 0, 0, 1, 1); cycle();
    update(32'h100, 0, 0); sample_check();
    check("flush_no_mp", bus.ex_mispredict, 0);
    advance();

    // force four more mispredicts: 2-bit stats must pin at 3
    for (int k = 0; k < 4; k++) begin
      lookup(32'h100); sample_check(); tk = !e_pt; advance();
      update(32'h100, tk, 32'h100); sample_check();
      check("forced_mp", bus.ex_mispredict, 1);
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); sample_check();
    check("s2_mp_pinned", bus_s.stat_mispredicts, 3);
    advance();

    // reset during an update
    update(32'h80, 1, 32'h500);
    rst = 1'b1;
    model_reset();
    cycle();
    rst = 1'b0;
    lookup(32'h100); sample_check(); check("rst_empty_100", bus.pred_taken, 0); advance();
    lookup(32'h80); sample_check(); check("rst_empty_80", bus.pred_taken, 0); advance();
    check("rst_stats", bus.stat_lookups, 2);

    // fall-through PC wraps
    drive(1, 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0); sample_check();
    check("npc_wrap", bus.npc, 0);
    advance();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      pc = pc_pool[$urandom_range(0, 7)];
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, pc,
            $urandom_range(0, 2) != 0,
            ($urandom_range(0, 1) == 1) ? bus.id_pc : pc_pool[$urandom_range(0, 7)],
            $urandom_range(0, 1) == 1, tg_pool[$urandom_range(0, 3)],
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
